// File: rtl/ysyx_23060171_npc_pred_if.sv
// Fetch-lookup and resolve-update bus between the pipeline and the next-PC predictor.
// The pipeline side is the master; the predictor is the slave.
interface ysyx_23060171_npc_pred_if #(
  parameter int XLEN = 32
);
  // fetch-side lookup
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic            p_taken;
  logic [XLEN-1:0] p_npc;
  // resolve-side update
  logic            u_valid;
  logic [XLEN-1:0] u_pc;
  logic [1:0]      u_kind;
  logic            u_taken;
  logic [XLEN-1:0] u_target;
  logic            u_pred_taken;
  logic [XLEN-1:0] u_pred_npc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     mispred_cnt;

  modport master (
    output f_valid, f_pc,
    output u_valid, u_pc, u_kind, u_taken, u_target, u_pred_taken, u_pred_npc,
    input  p_taken, p_npc, redirect, redirect_pc, mispred_cnt
  );

  modport slave (
    input  f_valid, f_pc,
    input  u_valid, u_pc, u_kind, u_taken, u_target, u_pred_taken, u_pred_npc,
    output p_taken, p_npc, redirect, redirect_pc, mispred_cnt
  );
endinterface

// File: rtl/ysyx_23060171_npc_pred.sv
// Direct-mapped next-PC predictor: per-entry tag/kind/target plus a 2-bit
// direction counter. Combinational lookup at fetch, edge-triggered training at
// resolve, combinational mispredict redirect and a saturating mispredict counter.
module ysyx_23060171_npc_pred #(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_23060171_npc_pred_if.slave   bus
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_BR   = 2'b01;

  // 2-bit counter saturating at 11
  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  // 2-bit counter saturating at 00
  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // 32-bit event counter saturating at all-ones
  function automatic logic [31:0] mis_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic            valid_q [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [1:0]      kind_q  [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic [31:0]     mis_q;

  // u_pred_taken travels with the instruction but the redirect decision only
  // needs the predicted next PC.
  logic unused_pred_taken;
  assign unused_pred_taken = bus.u_pred_taken;

  logic [IDX-1:0]  f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;
  logic            f_take;

  assign f_idx = bus.f_pc[IDX+1:2];
  assign f_tag = bus.f_pc[XLEN-1:IDX+2];

  // Fetch lookup: unconditional jumps always redirect fetch on a hit, branches
  // only when the counter's upper bit says taken.
  always_comb begin
    f_hit  = bus.f_valid && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_take = f_hit && (kind_q[f_idx][1] ||
                       ((kind_q[f_idx] == K_BR) && cnt_q[f_idx][1]));
  end

  assign bus.p_taken = f_take;
  assign bus.p_npc   = f_take ? tgt_q[f_idx] : bus.f_pc + XLEN'(4);

  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] u_tag;
  logic            u_hit;

  assign u_idx = bus.u_pc[IDX+1:2];
  assign u_tag = bus.u_pc[XLEN-1:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  logic            ctl_we;
  logic            dat_we;
  logic            nxt_valid;
  logic [1:0]      nxt_cnt;
  logic [1:0]      nxt_kind;
  logic [XLEN-1:0] nxt_tgt;

  // Training decision: which parts of the indexed entry change and to what.
  always_comb begin
    ctl_we    = 1'b0;
    dat_we    = 1'b0;
    nxt_valid = valid_q[u_idx];
    nxt_cnt   = cnt_q[u_idx];
    nxt_kind  = kind_q[u_idx];
    nxt_tgt   = tgt_q[u_idx];
    if (bus.u_valid) begin
      case (bus.u_kind)
        K_BR: begin
          if (u_hit) begin
            ctl_we  = 1'b1;
            nxt_cnt = bus.u_taken ? cnt_inc(cnt_q[u_idx]) : cnt_dec(cnt_q[u_idx]);
            if (bus.u_taken) begin
              dat_we  = 1'b1;
              nxt_tgt = bus.u_target;
            end
          end else if (bus.u_taken) begin
            // first taken sighting allocates weakly-taken; not-taken misses are ignored
            ctl_we    = 1'b1;
            dat_we    = 1'b1;
            nxt_valid = 1'b1;
            nxt_cnt   = 2'b10;
            nxt_kind  = K_BR;
            nxt_tgt   = bus.u_target;
          end
        end
        K_NONE: begin
          // a non-control instruction aliasing a live entry evicts it
          if (u_hit) begin
            ctl_we    = 1'b1;
            nxt_valid = 1'b0;
          end
        end
        default: begin
          ctl_we    = 1'b1;
          dat_we    = 1'b1;
          nxt_valid = 1'b1;
          nxt_cnt   = 2'b11;
          nxt_kind  = bus.u_kind;
          nxt_tgt   = bus.u_target;
        end
      endcase
    end
  end

  // Control state: valid bits and counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_INIT;
      end
    end else if (ctl_we) begin
      valid_q[u_idx] <= nxt_valid;
      cnt_q[u_idx]   <= nxt_cnt;
    end
  end

  // Entry payload: tag/kind/target need no reset because valid gates them.
  always_ff @(posedge clk) begin
    if (dat_we && !rst) begin
      tag_q[u_idx]  <= u_tag;
      kind_q[u_idx] <= nxt_kind;
      tgt_q[u_idx]  <= nxt_tgt;
    end
  end

  logic [XLEN-1:0] u_seq;
  logic [XLEN-1:0] u_correct;
  logic            redir;

  // Resolve check: compare the carried prediction against the real next PC.
  always_comb begin
    u_seq     = bus.u_pc + XLEN'(4);
    u_correct = ((bus.u_kind != K_NONE) && bus.u_taken) ? bus.u_target : u_seq;
    redir     = bus.u_valid && (bus.u_pred_npc != u_correct);
  end

  assign bus.redirect    = redir;
  assign bus.redirect_pc = redir ? u_correct : u_seq;

  // Mispredict counter, saturating; reset wins over a same-edge redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 32'd0;
    end else if (redir) begin
      mis_q <= mis_inc(mis_q);
    end
  end

  assign bus.mispred_cnt = mis_q;

endmodule
